exu_ctl: RTL and testbench
==========================

Name: exu_ctl

Overview:
Stage controller that sequences the execute unit (exu) between the decode stage (idu) and the load/store stage (lsu). It latches one decoded instruction, presents operands and control to exu, and waits for exu completion. It then holds the result for lsu under a valid/ready handshake. On a taken jump it issues a one-cycle redirect to ifu and flushes younger work, and a watchdog catches an exu that never completes.

Parameters:
DATA_WIDTH, 32, width of pc, operands and result
ARGS_WIDTH, `ARGS_WIDTH (cfg.sv), width of alu/jmp type fields
TIMEOUT_CYCLES, 16, max EXEC cycles waiting for i_exu_valid (>=2)

Ports:
i_sys_clk  in  1  clock; single clock domain
i_sys_rst  in  1  reset, asynchronous, active-high
i_idu_valid  in  1  decoded instruction available
o_idu_ready  out  1  controller accepts instruction this cycle
i_idu_pc  in  DATA_WIDTH  instruction pc
i_idu_alu_type / i_idu_jmp_type  in  ARGS_WIDTH  ALU_TYPE_* / JMP_* codes
i_idu_rs1_data / i_idu_rs2_data / i_idu_jmp_or_reg_data  in  DATA_WIDTH  operands
i_idu_rd_addr  in  5  destination register; i_idu_rd_wr_en  in  1  writeback enable
o_exu_ready  out  1  to exu i_sys_ready; i_exu_valid  in  1  from exu o_sys_valid
o_exu_pc / o_exu_rs1_data / o_exu_rs2_data / o_exu_jmp_or_reg_data  out  DATA_WIDTH  registered operands
o_exu_alu_type / o_exu_jmp_type  out  ARGS_WIDTH  registered control
i_exu_res / i_exu_jmp_pc  in  DATA_WIDTH;  i_exu_jmp_en  in  1  exu results
o_lsu_valid  out  1;  i_lsu_ready  in  1  downstream handshake
o_lsu_pc / o_lsu_res  out  DATA_WIDTH;  o_lsu_rd_addr  out  5;  o_lsu_rd_wr_en  out  1
o_ifu_redirect_en  out  1;  o_ifu_redirect_pc  out  DATA_WIDTH  jump redirect
o_flush  out  1  flush ifu/idu younger instructions
o_err_timeout  out  1  sticky watchdog error
o_perf_retire  out  32  count of lsu handshakes

Behaviour:
- Reset (async): state=IDLE; every output is 0 (operand/result registers are 0 and o_idu_ready=0 during reset). After release, o_idu_ready follows the rules below.
- States: IDLE, EXEC, DONE.
- IDLE: o_idu_ready=1. On i_idu_valid, latch all idu fields into o_exu_* and rd regs, then go to EXEC.
- EXEC: o_exu_ready=1 and o_idu_ready=0. The timeout counter increments each cycle.
- EXEC, i_exu_valid=1: latch i_exu_res into o_lsu_res and capture i_exu_jmp_en / i_exu_jmp_pc. Clear the counter and go to DONE.
- EXEC, timeout: if i_exu_valid=0 and count==TIMEOUT_CYCLES-1, set o_err_timeout and go to DONE with o_lsu_res=0, o_lsu_rd_wr_en=0 and no redirect.
- If i_exu_valid and timeout coincide, exu completion wins.
- o_err_timeout clears only on reset.
- DONE: o_lsu_valid=1. Payload is stable until the handshake completes.
- First DONE cycle with a captured jump: o_ifu_redirect_en=1 and o_flush=1 for exactly one cycle, with o_ifu_redirect_pc equal to the captured pc. o_idu_ready=0 in that cycle regardless of i_lsu_ready.
- Other DONE cycles: o_idu_ready = i_lsu_ready (combinational).
- DONE, i_lsu_ready=1: increment o_perf_retire, which wraps at 2^32.
- DONE exit, back-to-back: if i_idu_valid && o_idu_ready, latch the new instruction and go to EXEC.
- DONE exit, otherwise: go to IDLE.
- DONE, i_lsu_ready=0: stay in DONE and hold all outputs.
- Latency: at least 2 cycles from idu accept to o_lsu_valid (accept, one EXEC cycle, DONE). Throughput is one instruction per 2 cycles when exu completes in one cycle.
- Reset mid-EXEC or mid-DONE: the instruction is dropped, no retire count, no redirect.

Decomposition:
- Package exu_ctl_pkg: state enum (IDLE/EXEC/DONE) and struct for the latched idu bundle.
- ALU_TYPE_*, JMP_* and ARGS_WIDTH stay in cfg.sv.
- One sub-module, exu_ctl_wdog: the timeout counter, with ports clr, en, hit.

Test Plan:
- Reset, then idu sends pc=0x8000_0000, ADD, rs1=1, rs2=2, rd=5, wr_en=1; stub exu returns res=3 one cycle later -> o_lsu_valid with res=3, rd=5, retire=1, no redirect.
- Stub returns jmp_en=1, jmp_pc=0x8000_0003 -> single-cycle o_ifu_redirect_en/o_flush with pc 0x8000_0003; o_idu_ready=0 that cycle even with lsu_ready=1.
- i_lsu_ready held 0 for 4 cycles in DONE -> payload stable, o_idu_ready=0, retire unchanged; ready=1 -> retire increments once.
- Back-to-back: idu_valid continuous, lsu_ready=1, exu 1-cycle -> new instruction accepted in DONE cycle; 3 instructions retire in 6 cycles.
- Stub never asserts i_exu_valid -> after 16 EXEC cycles o_err_timeout=1 (sticky), o_lsu_res=0, wr_en=0; i_exu_valid on cycle 16 -> normal completion, no error.
- Assert i_sys_rst mid-EXEC -> all outputs 0 immediately, retire=0, state IDLE after release.

Source files
------------

// File: rtl/exu_ctl_pkg.sv
// exu_ctl_pkg: shared types for the execute-stage controller.
//   state_t      - controller FSM states
//   idu_bundle_t - decoded instruction as latched from idu
//   ALU_*/JMP_*  - typed aliases of the cfg codes
`ifndef ARGS_WIDTH
`include "cfg.sv"
`endif

package exu_ctl_pkg;
  localparam int XLEN   = 32;
  localparam int ARGS_W = `ARGS_WIDTH;

  localparam logic [ARGS_W-1:0] ALU_ADD  = `ALU_TYPE_ADD;
  localparam logic [ARGS_W-1:0] ALU_SUB  = `ALU_TYPE_SUB;
  localparam logic [ARGS_W-1:0] ALU_XOR  = `ALU_TYPE_XOR;
  localparam logic [ARGS_W-1:0] JMP_NONE = `JMP_NONE;
  localparam logic [ARGS_W-1:0] JMP_JAL  = `JMP_JAL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [ARGS_W-1:0] alu_type;
    logic [ARGS_W-1:0] jmp_type;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   jmp_or_reg_data;
    logic [4:0]        rd_addr;
    logic              rd_wr_en;
  } idu_bundle_t;
endpackage

// File: rtl/exu_ctl_if.sv
// exu_ctl_if: all idu/exu/lsu/ifu signals of the execute-stage controller.
//   master - the controller (drives o_*, samples i_*)
//   slave  - surrounding pipeline stages (drive i_*, sample o_*)
interface exu_ctl_if #(
  parameter int DW = 32,
  parameter int AW = exu_ctl_pkg::ARGS_W
) ();
  // idu -> controller
  logic          i_idu_valid;
  logic          o_idu_ready;
  logic [DW-1:0] i_idu_pc;
  logic [AW-1:0] i_idu_alu_type;
  logic [AW-1:0] i_idu_jmp_type;
  logic [DW-1:0] i_idu_rs1_data;
  logic [DW-1:0] i_idu_rs2_data;
  logic [DW-1:0] i_idu_jmp_or_reg_data;
  logic [4:0]    i_idu_rd_addr;
  logic          i_idu_rd_wr_en;
  // controller <-> exu
  logic          o_exu_ready;
  logic          i_exu_valid;
  logic [DW-1:0] o_exu_pc;
  logic [DW-1:0] o_exu_rs1_data;
  logic [DW-1:0] o_exu_rs2_data;
  logic [DW-1:0] o_exu_jmp_or_reg_data;
  logic [AW-1:0] o_exu_alu_type;
  logic [AW-1:0] o_exu_jmp_type;
  logic [DW-1:0] i_exu_res;
  logic [DW-1:0] i_exu_jmp_pc;
  logic          i_exu_jmp_en;
  // controller -> lsu
  logic          o_lsu_valid;
  logic          i_lsu_ready;
  logic [DW-1:0] o_lsu_pc;
  logic [DW-1:0] o_lsu_res;
  logic [4:0]    o_lsu_rd_addr;
  logic          o_lsu_rd_wr_en;
  // ifu redirect, status
  logic          o_ifu_redirect_en;
  logic [DW-1:0] o_ifu_redirect_pc;
  logic          o_flush;
  logic          o_err_timeout;
  logic [31:0]   o_perf_retire;

  modport master (
    input  i_idu_valid, i_idu_pc, i_idu_alu_type, i_idu_jmp_type, i_idu_rs1_data,
           i_idu_rs2_data, i_idu_jmp_or_reg_data, i_idu_rd_addr, i_idu_rd_wr_en,
           i_exu_valid, i_exu_res, i_exu_jmp_pc, i_exu_jmp_en, i_lsu_ready,
    output o_idu_ready, o_exu_ready, o_exu_pc, o_exu_rs1_data, o_exu_rs2_data,
           o_exu_jmp_or_reg_data, o_exu_alu_type, o_exu_jmp_type, o_lsu_valid,
           o_lsu_pc, o_lsu_res, o_lsu_rd_addr, o_lsu_rd_wr_en, o_ifu_redirect_en,
           o_ifu_redirect_pc, o_flush, o_err_timeout, o_perf_retire
  );

  modport slave (
    output i_idu_valid, i_idu_pc, i_idu_alu_type, i_idu_jmp_type, i_idu_rs1_data,
           i_idu_rs2_data, i_idu_jmp_or_reg_data, i_idu_rd_addr, i_idu_rd_wr_en,
           i_exu_valid, i_exu_res, i_exu_jmp_pc, i_exu_jmp_en, i_lsu_ready,
    input  o_idu_ready, o_exu_ready, o_exu_pc, o_exu_rs1_data, o_exu_rs2_data,
           o_exu_jmp_or_reg_data, o_exu_alu_type, o_exu_jmp_type, o_lsu_valid,
           o_lsu_pc, o_lsu_res, o_lsu_rd_addr, o_lsu_rd_wr_en, o_ifu_redirect_en,
           o_ifu_redirect_pc, o_flush, o_err_timeout, o_perf_retire
  );
endinterface

// File: rtl/cfg.sv
// Shared core configuration: width of the ALU/jump type fields and their codes.
// Guarded so it can be both compiled directly and pulled in by the package.
`ifndef EXU_CFG_SV
`define EXU_CFG_SV

`define ARGS_WIDTH   4

`define ALU_TYPE_ADD 4'd0
`define ALU_TYPE_SUB 4'd1
`define ALU_TYPE_XOR 4'd2

`define JMP_NONE     4'd0
`define JMP_JAL      4'd1

`endif

// File: rtl/exu_ctl_wdog.sv
// exu_ctl_wdog: cycle counter bounding how long the controller waits on exu.
//   clk, rst - clock, async active-high reset
//   clr      - zero the counter (has priority over en)
//   en       - count this cycle
//   hit      - en is set and this is the TIMEOUT_CYCLES-th counted cycle
module exu_ctl_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign hit = en && (cnt == LAST);
endmodule

// File: rtl/exu_ctl.sv
// exu_ctl: execute-stage controller between idu and lsu.
//   i_sys_clk, i_sys_rst - clock, async active-high reset
//   bus (master)         - idu accept, exu operands/results, lsu valid/ready,
//                          ifu redirect/flush, sticky timeout, retire counter
// IDLE accepts an instruction, EXEC waits for exu (bounded by the watchdog),
// DONE holds the result for lsu and may accept the next instruction on the
// handshake cycle, giving one instruction per two cycles with a 1-cycle exu.
module exu_ctl
  import exu_ctl_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic       i_sys_clk,
  input logic       i_sys_rst,
  exu_ctl_if.master bus
);
  state_t                state, state_nxt;
  idu_bundle_t           idu_q;
  logic [DATA_WIDTH-1:0] res_q, jmp_pc_q;
  logic                  wr_en_q, redir_q, err_q;
  logic [31:0]           retire_q;
  logic                  idu_ready, exu_ready, lsu_valid;
  logic                  accept, exu_done, wd_hit, hshk;

  assign accept   = bus.i_idu_valid && idu_ready;
  assign exu_done = (state == EXEC) && (bus.i_exu_valid || wd_hit);
  assign hshk     = lsu_valid && bus.i_lsu_ready;

  exu_ctl_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk (i_sys_clk),
    .rst (i_sys_rst),
    .clr ((state != EXEC) || exu_done),
    .en  (state == EXEC),
    .hit (wd_hit)
  );

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_idu_valid) state_nxt = EXEC;
      EXEC:    if (exu_done) state_nxt = DONE;
      DONE:    if (bus.i_lsu_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idu_ready is gated by reset so it reads 0 while reset is held in IDLE.
  // On the redirect cycle younger fetches are being flushed, so nothing new
  // is taken even if lsu drains this instruction.
  always_comb begin
    idu_ready = 1'b0;
    exu_ready = 1'b0;
    lsu_valid = 1'b0;
    case (state)
      IDLE: idu_ready = !i_sys_rst;
      EXEC: exu_ready = 1'b1;
      DONE: begin
        lsu_valid = 1'b1;
        idu_ready = bus.i_lsu_ready && !redir_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      idu_q    <= '0;
      res_q    <= '0;
      jmp_pc_q <= '0;
      wr_en_q  <= 1'b0;
      redir_q  <= 1'b0;
      err_q    <= 1'b0;
      retire_q <= '0;
    end else begin
      if (accept) begin
        idu_q.pc              <= bus.i_idu_pc;
        idu_q.alu_type        <= bus.i_idu_alu_type;
        idu_q.jmp_type        <= bus.i_idu_jmp_type;
        idu_q.rs1_data        <= bus.i_idu_rs1_data;
        idu_q.rs2_data        <= bus.i_idu_rs2_data;
        idu_q.jmp_or_reg_data <= bus.i_idu_jmp_or_reg_data;
        idu_q.rd_addr         <= bus.i_idu_rd_addr;
        idu_q.rd_wr_en        <= bus.i_idu_rd_wr_en;
      end
      // redir_q is only ever high for the first DONE cycle.
      redir_q <= 1'b0;
      if (exu_done) begin
        if (bus.i_exu_valid) begin
          res_q    <= bus.i_exu_res;
          wr_en_q  <= idu_q.rd_wr_en;
          jmp_pc_q <= bus.i_exu_jmp_pc;
          redir_q  <= bus.i_exu_jmp_en;
        end else begin
          // Timed out: retire a harmless bubble, no writeback, no redirect.
          res_q    <= '0;
          wr_en_q  <= 1'b0;
          jmp_pc_q <= '0;
          err_q    <= 1'b1;
        end
      end
      if (hshk) retire_q <= retire_q + 32'd1;
    end
  end

  assign bus.o_idu_ready           = idu_ready;
  assign bus.o_exu_ready           = exu_ready;
  assign bus.o_exu_pc              = idu_q.pc;
  assign bus.o_exu_alu_type        = idu_q.alu_type;
  assign bus.o_exu_jmp_type        = idu_q.jmp_type;
  assign bus.o_exu_rs1_data        = idu_q.rs1_data;
  assign bus.o_exu_rs2_data        = idu_q.rs2_data;
  assign bus.o_exu_jmp_or_reg_data = idu_q.jmp_or_reg_data;
  assign bus.o_lsu_valid           = lsu_valid;
  assign bus.o_lsu_pc              = idu_q.pc;
  assign bus.o_lsu_res             = res_q;
  assign bus.o_lsu_rd_addr         = idu_q.rd_addr;
  assign bus.o_lsu_rd_wr_en        = wr_en_q;
  assign bus.o_ifu_redirect_en     = redir_q;
  assign bus.o_ifu_redirect_pc     = jmp_pc_q;
  assign bus.o_flush               = redir_q;
  assign bus.o_err_timeout         = err_q;
  assign bus.o_perf_retire         = retire_q;
endmodule

// File: tb/tb_exu_ctl.sv
// tb_exu_ctl: table-driven bench for exu_ctl with a stub exu and an lsu-side
// scoreboard (expected payload queued at idu accept, compared at handshake).
module tb_exu_ctl;
  import exu_ctl_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_ctl_if #(.DW(32), .AW(ARGS_W)) bus ();

  exu_ctl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stub exu ----------------
  int              cur_lat = 1;   // EXEC cycle on which exu answers; 0 = never
  logic            cur_jmp_en = 1'b0;
  logic [31:0]     cur_jmp_pc = '0;

  function automatic logic [31:0] alu_f(input logic [ARGS_W-1:0] t, input logic [31:0] a,
                                        input logic [31:0] b);
    case (t)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin : stub
    int n;
    n = 0;
    bus.i_exu_valid  = 1'b0;
    bus.i_exu_res    = '0;
    bus.i_exu_jmp_en = 1'b0;
    bus.i_exu_jmp_pc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_exu_ready) begin
        n++;
        bus.i_exu_valid = (cur_lat != 0) && (n == cur_lat);
        bus.i_exu_res   = alu_f(bus.o_exu_alu_type, bus.o_exu_rs1_data, bus.o_exu_rs2_data);
      end else begin
        n = 0;
        bus.i_exu_valid = 1'b0;
      end
      // jmp_en may be high without valid; the controller must ignore it then.
      bus.i_exu_jmp_en = cur_jmp_en;
      bus.i_exu_jmp_pc = cur_jmp_pc;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } sb_t;
  sb_t sbq[$];

  initial begin : mon
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_lsu_valid && bus.i_lsu_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=pc%0h expected=none", bus.o_lsu_pc);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", bus.o_lsu_pc, e.pc);
          chk("sb_res", bus.o_lsu_res, e.res);
          chk("sb_rd", bus.o_lsu_rd_addr, e.rd);
          chk("sb_wr_en", bus.o_lsu_rd_wr_en, e.we);
        end
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0]       pc;
    logic [ARGS_W-1:0] alu;
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    logic [4:0]        rd;
    logic              we;
    int                lat;
    logic              jmp_en;
    logic [31:0]       jmp_pc;
    int                stall;
    logic [31:0]       exp_res;
    logic              exp_we;
    logic              exp_redir;
    logic              exp_err;
  } vec_t;

  vec_t vecs[7];
  int   exp_retire = 0;

  task automatic drive_idu(input logic [31:0] pc, input logic [ARGS_W-1:0] alu,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic we, input logic jmp);
    bus.i_idu_pc              = pc;
    bus.i_idu_alu_type        = alu;
    bus.i_idu_jmp_type        = jmp ? JMP_JAL : JMP_NONE;
    bus.i_idu_rs1_data        = rs1;
    bus.i_idu_rs2_data        = rs2;
    bus.i_idu_jmp_or_reg_data = pc + 32'd4;
    bus.i_idu_rd_addr         = rd;
    bus.i_idu_rd_wr_en        = we;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    cur_lat    = v.lat;
    cur_jmp_en = v.jmp_en;
    cur_jmp_pc = v.jmp_pc;
    drive_idu(v.pc, v.alu, v.rs1, v.rs2, v.rd, v.we, v.jmp_en);
    bus.i_idu_valid = 1'b1;
    bus.i_lsu_ready = (v.stall == 0);
    chk("idle_idu_ready", bus.o_idu_ready, 1);
    sbq.push_back('{v.pc, v.exp_res, v.rd, v.exp_we});
    tick;
    bus.i_idu_valid = 1'b0;
    chk("exec_exu_ready", bus.o_exu_ready, 1);
    chk("exec_idu_ready", bus.o_idu_ready, 0);
    chk("exec_pc", bus.o_exu_pc, v.pc);
    chk("exec_rs1", bus.o_exu_rs1_data, v.rs1);
    chk("exec_rs2", bus.o_exu_rs2_data, v.rs2);
    chk("exec_alu", bus.o_exu_alu_type, v.alu);
    chk("exec_jmp_type", bus.o_exu_jmp_type, v.jmp_en ? JMP_JAL : JMP_NONE);
    chk("exec_jor", bus.o_exu_jmp_or_reg_data, v.pc + 32'd4);
    n = 0;
    while (!bus.o_lsu_valid && n < TO + 4) begin
      tick;
      n++;
    end
    chk("exec_cycles", n, (v.lat == 0) ? TO : v.lat);
    chk("done_redirect", bus.o_ifu_redirect_en, v.exp_redir);
    chk("done_flush", bus.o_flush, v.exp_redir);
    if (v.exp_redir) chk("done_redirect_pc", bus.o_ifu_redirect_pc, v.jmp_pc);
    chk("done_err", bus.o_err_timeout, v.exp_err);
    chk("done_idu_ready", bus.o_idu_ready, (v.stall == 0) && !v.exp_redir);
    chk("done_retire", bus.o_perf_retire, exp_retire);
    for (int s = 0; s < v.stall; s++) begin
      tick;
      chk("stall_valid", bus.o_lsu_valid, 1);
      chk("stall_res", bus.o_lsu_res, v.exp_res);
      chk("stall_pc", bus.o_lsu_pc, v.pc);
      chk("stall_idu_ready", bus.o_idu_ready, 0);
      chk("stall_retire", bus.o_perf_retire, exp_retire);
      chk("stall_redirect", bus.o_ifu_redirect_en, 0);
    end
    if (v.stall != 0) begin
      bus.i_lsu_ready = 1'b1;
      #1;
      chk("release_idu_ready", bus.o_idu_ready, 1);
    end
    tick;
    exp_retire++;
    chk("post_retire", bus.o_perf_retire, exp_retire);
    chk("post_valid", bus.o_lsu_valid, 0);
    chk("post_redirect", bus.o_ifu_redirect_en, 0);
    chk("post_flush", bus.o_flush, 0);
  endtask

  // ---------------- main ----------------
  initial begin : main
    int          k;
    logic        acc;
    logic [31:0] base;

    vecs[0] = '{32'h8000_0000, ALU_ADD, 32'd1, 32'd2, 5'd5, 1'b1, 1, 1'b0, 32'h0, 0,
                32'd3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h8000_0004, ALU_ADD, 32'd10, 32'd20, 5'd1, 1'b1, 1, 1'b1, 32'h8000_0003, 0,
                32'd30, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0008, ALU_SUB, 32'd5, 32'd7, 5'd31, 1'b1, 3, 1'b0, 32'h0, 4,
                32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_000C, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 1'b0, 2, 1'b0, 32'h0, 0,
                32'h0000_FF00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0010, ALU_ADD, 32'd100, 32'd1, 5'd7, 1'b1, TO, 1'b0, 32'h0, 0,
                32'd101, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0014, ALU_ADD, 32'd3, 32'd4, 5'd9, 1'b1, 0, 1'b1, 32'h8000_0100, 2,
                32'd0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0018, ALU_SUB, 32'd9, 32'd4, 5'd2, 1'b1, 1, 1'b0, 32'h0, 0,
                32'd5, 1'b1, 1'b0, 1'b1};

    bus.i_idu_valid = 1'b0;
    bus.i_lsu_ready = 1'b0;
    drive_idu('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // reset state
    repeat (3) tick;
    chk("rst_idu_ready", bus.o_idu_ready, 0);
    chk("rst_exu_ready", bus.o_exu_ready, 0);
    chk("rst_lsu_valid", bus.o_lsu_valid, 0);
    chk("rst_exu_pc", bus.o_exu_pc, 0);
    chk("rst_lsu_res", bus.o_lsu_res, 0);
    chk("rst_redirect", bus.o_ifu_redirect_en, 0);
    chk("rst_flush", bus.o_flush, 0);
    chk("rst_err", bus.o_err_timeout, 0);
    chk("rst_retire", bus.o_perf_retire, 0);
    rst = 1'b0;
    #1;
    chk("rel_idu_ready", bus.o_idu_ready, 1);
    tick;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset while in EXEC: instruction dropped, sticky error cleared
    cur_lat    = 0;
    cur_jmp_en = 1'b1;
    cur_jmp_pc = 32'h8000_0200;
    drive_idu(32'h8000_0040, ALU_ADD, 32'd1, 32'd1, 5'd3, 1'b1, 1'b1);
    bus.i_idu_valid = 1'b1;
    bus.i_lsu_ready = 1'b1;
    sbq.push_back('{32'h8000_0040, 32'd0, 5'd3, 1'b0});
    tick;
    bus.i_idu_valid = 1'b0;
    tick;
    tick;
    chk("mid_exec_state", bus.o_exu_ready, 1);
    rst = 1'b1;
    #1;
    sbq.delete();
    chk("mrst_exu_ready", bus.o_exu_ready, 0);
    chk("mrst_idu_ready", bus.o_idu_ready, 0);
    chk("mrst_lsu_valid", bus.o_lsu_valid, 0);
    chk("mrst_exu_pc", bus.o_exu_pc, 0);
    chk("mrst_retire", bus.o_perf_retire, 0);
    chk("mrst_err", bus.o_err_timeout, 0);
    chk("mrst_redirect", bus.o_ifu_redirect_en, 0);
    tick;
    rst = 1'b0;
    exp_retire = 0;
    #1;
    chk("mrel_idu_ready", bus.o_idu_ready, 1);
    tick;
    chk("mrel_lsu_valid", bus.o_lsu_valid, 0);
    chk("mrel_retire", bus.o_perf_retire, 0);

    // back-to-back: accept in DONE, 3 retire within 6 cycles of the first accept
    cur_lat    = 1;
    cur_jmp_en = 1'b0;
    base       = exp_retire;
    k          = 0;
    drive_idu(32'h9000_0000, ALU_ADD, 32'd0, 32'd10, 5'd10, 1'b1, 1'b0);
    bus.i_idu_valid = 1'b1;
    bus.i_lsu_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      acc = bus.i_idu_valid && bus.o_idu_ready;
      if (c == 2) begin
        chk("b2b_done_valid", bus.o_lsu_valid, 1);
        chk("b2b_done_accept", bus.o_idu_ready, 1);
      end
      if (acc) sbq.push_back('{32'h9000_0000 + 32'(4 * k), 32'(k + 10), 5'(10 + k), 1'b1});
      tick;
      if (acc) begin
        k++;
        if (k < 3) drive_idu(32'h9000_0000 + 32'(4 * k), ALU_ADD, 32'(k), 32'd10, 5'(10 + k),
                             1'b1, 1'b0);
        else bus.i_idu_valid = 1'b0;
      end
      if (c == 5) chk("b2b_retire_5", bus.o_perf_retire, base + 32'd2);
      if (c == 6) begin
        chk("b2b_retire_6", bus.o_perf_retire, base + 32'd3);
        chk("b2b_idle", bus.o_lsu_valid, 0);
      end
    end
    chk("b2b_accepted", k, 3);
    exp_retire += 3;

    tick;
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
